// File: rtl/mem_addrgen_pkg.sv
// Shared types and widths for the affine address/schedule generator.
// Holds the FSM state encoding, the latched configuration layout and a
// helper that normalises the requested loop-nest depth.
package mem_addrgen_pkg;

    localparam int MAX_DIMS   = 4;
    localparam int ADDR_WIDTH = 16;
    localparam int CYC_WIDTH  = 16;
    localparam int EXT_WIDTH  = 16;
    localparam int DIM_W      = 3;
    localparam int SEL_W      = (MAX_DIMS > 1) ? $clog2(MAX_DIMS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Configuration captured on a start pulse; dim0 is the innermost loop.
    typedef struct packed {
        logic [DIM_W-1:0]                      num_dims;
        logic [MAX_DIMS-1:0][EXT_WIDTH-1:0]    extent_m1;
        logic [MAX_DIMS-1:0][ADDR_WIDTH-1:0]   addr_delta;
        logic [MAX_DIMS-1:0][CYC_WIDTH-1:0]    sched_delta;
    } cfg_t;

    // Zero dims behaves as one; anything above the supported depth is clamped.
    function automatic logic [DIM_W-1:0] eff_dims(input logic [DIM_W-1:0] n);
        logic [DIM_W-1:0] r;
        r = n;
        if (n == '0)
            r = DIM_W'(1);
        else if (n > DIM_W'(MAX_DIMS))
            r = DIM_W'(MAX_DIMS);
        return r;
    endfunction

endpackage

// File: rtl/mem_addrgen_iter.sv
// Loop-nest index counter. Reports the lowest active dimension that can
// still advance (the dimension that steps on the next issue) and a flag
// that is high when every active index sits at its final value.
module mem_addrgen_iter
    import mem_addrgen_pkg::*;
#(
    parameter int NUM_DIMS = MAX_DIMS,
    parameter int EXT_W    = EXT_WIDTH,
    parameter int IDX_W    = (NUM_DIMS > 1) ? $clog2(NUM_DIMS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      clear,
    input  logic                      step,
    input  logic [DIM_W-1:0]          num_dims,
    input  logic [NUM_DIMS*EXT_W-1:0] extent_m1,
    output logic [IDX_W-1:0]          step_dim,
    output logic                      last
);

    logic [NUM_DIMS-1:0] can_step;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIMS; gi++) begin : g_dim
            logic [EXT_W-1:0] idx_reg;

            assign can_step[gi] = (DIM_W'(gi) < num_dims) &&
                                  (idx_reg != extent_m1[gi*EXT_W +: EXT_W]);

            // Inner dims below the stepping dim wrap, the stepping dim advances.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    idx_reg <= '0;
                end else if (clk_en) begin
                    if (clear) begin
                        idx_reg <= '0;
                    end else if (step && !last) begin
                        if (IDX_W'(gi) < step_dim)
                            idx_reg <= '0;
                        else if (IDX_W'(gi) == step_dim)
                            idx_reg <= idx_reg + EXT_W'(1);
                    end
                end
            end
        end
    endgenerate

    // Priority pick of the lowest dimension that is not yet at its extent.
    always_comb begin
        step_dim = '0;
        for (int i = NUM_DIMS - 1; i >= 0; i--) begin
            if (can_step[i])
                step_dim = IDX_W'(i);
        end
        last = ~|can_step;
    end

endmodule

// File: rtl/mem_affine_addrgen.sv
// Affine loop-nest address/schedule generator for one memory port.
// A free-running pass counter is compared against an affine schedule
// accumulator; on a match an enable strobe is emitted together with the
// affine address accumulator, and both accumulators advance by the deltas
// of the dimension that steps.
// Optional: define MEM_ADDRGEN_MISS_DETECT_EN to flag a schedule that does
// not move strictly ahead of the counter after an issue (sticky err).
// Parameter widths are expected to match the mem_addrgen_pkg widths used by
// the latched configuration record.
module mem_affine_addrgen
    import mem_addrgen_pkg::*;
#(
    parameter int NUM_DIMS = MAX_DIMS,
    parameter int ADDR_W   = ADDR_WIDTH,
    parameter int CYC_W    = CYC_WIDTH,
    parameter int EXT_W    = EXT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       start,
    input  logic [2:0]                 cfg_num_dims,
    input  logic [NUM_DIMS*EXT_W-1:0]  cfg_extent_m1,
    input  logic [ADDR_W-1:0]          cfg_start_addr,
    input  logic [NUM_DIMS*ADDR_W-1:0] cfg_addr_delta,
    input  logic [CYC_W-1:0]           cfg_start_cycle,
    input  logic [NUM_DIMS*CYC_W-1:0]  cfg_sched_delta,
    output logic                       en,
    output logic [ADDR_W-1:0]          addr,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int IDX_W = (NUM_DIMS > 1) ? $clog2(NUM_DIMS) : 1;

    state_t            state_reg, state_next;
    cfg_t              cfg_reg;
    logic [CYC_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [CYC_W-1:0]  sched_reg;
    logic              done_reg;

    logic              issue;
    logic [IDX_W-1:0]  step_dim;
    logic              last;
    logic [ADDR_W-1:0] addr_next;
    logic [CYC_W-1:0]  sched_next;

    mem_addrgen_iter #(
        .NUM_DIMS (NUM_DIMS),
        .EXT_W    (EXT_W),
        .IDX_W    (IDX_W)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .clear     (start),
        .step      (issue && !start),
        .num_dims  (cfg_reg.num_dims),
        .extent_m1 (cfg_reg.extent_m1),
        .step_dim  (step_dim),
        .last      (last)
    );

    // Next-state logic and issue decode; outputs depend on registers only.
    always_comb begin
        state_next = state_reg;
        issue      = (state_reg == RUN) && clk_en && (cnt_reg == sched_reg);
        addr_next  = addr_reg + cfg_reg.addr_delta[step_dim];
        sched_next = sched_reg + cfg_reg.sched_delta[step_dim];
        if (clk_en) begin
            case (state_reg)
                IDLE: if (start) state_next = RUN;
                RUN: begin
                    if (start)
                        state_next = RUN;
                    else if (issue && last)
                        state_next = DONE;
                end
                DONE: if (start) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    assign en   = issue;
    assign addr = addr_reg;
    assign busy = (state_reg == RUN);
    assign done = done_reg;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Config latch, pass counter and affine accumulators.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_reg   <= '0;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            sched_reg <= '0;
            done_reg  <= 1'b0;
        end else if (clk_en) begin
            if (start) begin
                cfg_reg.num_dims    <= eff_dims(cfg_num_dims);
                cfg_reg.extent_m1   <= cfg_extent_m1;
                cfg_reg.addr_delta  <= cfg_addr_delta;
                cfg_reg.sched_delta <= cfg_sched_delta;
                cnt_reg             <= '0;
                addr_reg            <= cfg_start_addr;
                sched_reg           <= cfg_start_cycle;
                done_reg            <= 1'b0;
            end else if (state_reg == RUN) begin
                cnt_reg <= cnt_reg + CYC_W'(1);
                if (issue) begin
                    if (last) begin
                        done_reg <= 1'b1;
                    end else begin
                        addr_reg  <= addr_next;
                        sched_reg <= sched_next;
                    end
                end
            end
        end
    end

`ifdef MEM_ADDRGEN_MISS_DETECT_EN
    logic err_reg;

    // Sticky miss flag: the next scheduled cycle is not ahead of the counter,
    // so it can only be reached after the counter wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (clk_en) begin
            if (start)
                err_reg <= 1'b0;
            else if (issue && !last && (sched_next <= cnt_reg))
                err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_affine_addrgen.sv
// Scoreboard bench for mem_affine_addrgen: stimulus pushes the expected
// (addr, cycle-since-start) of each issue; a negedge monitor pops on en.
module tb_mem_affine_addrgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        start;
    logic [2:0]  cfg_num_dims;
    logic [63:0] cfg_extent_m1;
    logic [15:0] cfg_start_addr;
    logic [63:0] cfg_addr_delta;
    logic [15:0] cfg_start_cycle;
    logic [63:0] cfg_sched_delta;
    logic        en;
    logic [15:0] addr;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [15:0] addr;
        int          rel;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rel      = 0;

    always #5 clk = ~clk;

    mem_affine_addrgen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .start           (start),
        .cfg_num_dims    (cfg_num_dims),
        .cfg_extent_m1   (cfg_extent_m1),
        .cfg_start_addr  (cfg_start_addr),
        .cfg_addr_delta  (cfg_addr_delta),
        .cfg_start_cycle (cfg_start_cycle),
        .cfg_sched_delta (cfg_sched_delta),
        .en              (en),
        .addr            (addr),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    // Cycle index relative to the last accepted start (0 = first cycle after).
    always @(posedge clk) begin
        if (start && clk_en && rst_n)
            rel <= 0;
        else
            rel <= rel + 1;
    end

    // Monitor: every en must match the head of the expected queue.
    always @(negedge clk) begin
        if (en === 1'b1) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL issue: unexpected en addr=%0d rel=%0d (none expected)", addr, rel);
            end else begin
                e = q.pop_front();
                if (addr !== e.addr || rel != e.rel) begin
                    failures++;
                    $display("FAIL issue: got addr=%0d rel=%0d expected addr=%0d rel=%0d",
                             addr, rel, e.addr, e.rel);
                end else begin
                    $display("issue ok: addr=%0d rel=%0d", addr, rel);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("check ok: %s = %0d", name, act);
        end
    endtask

    task automatic push(input logic [15:0] a, input int r);
        exp_t e;
        e.addr = a;
        e.rel  = r;
        q.push_back(e);
    endtask

    task automatic wait_rel(input int target);
        int n;
        n = 0;
        while (rel != target && n < 300) begin
            tick();
            n++;
        end
        if (rel != target) begin
            checks++;
            failures++;
            $display("FAIL timeout: rel=%0d expected %0d", rel, target);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic cfg_1d(input logic [15:0] sa, input logic [15:0] sc);
        cfg_num_dims    = 3'd1;
        cfg_extent_m1   = {16'd7, 16'd7, 16'd7, 16'd3};
        cfg_start_addr  = sa;
        cfg_addr_delta  = {16'd9, 16'd9, 16'd9, 16'd1};
        cfg_start_cycle = sc;
        cfg_sched_delta = {16'd9, 16'd9, 16'd9, 16'd1};
    endtask

    initial begin
        rst_n  = 1'b0;
        clk_en = 1'b1;
        start  = 1'b0;
        cfg_1d(16'd10, 16'd5);
        repeat (3) tick();
        check("reset_en", {31'd0, en}, 0);
        check("reset_addr", {16'd0, addr}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_err", {31'd0, err}, 0);
        rst_n = 1'b1;
        tick();

        // 1D pass: en at cnt 5..8, done from cnt 9.
        push(16'd10, 5); push(16'd11, 6); push(16'd12, 7); push(16'd13, 8);
        do_start();
        check("1d_busy0", {31'd0, busy}, 1);
        wait_rel(8);
        check("1d_done_rel8", {31'd0, done}, 0);
        wait_rel(9);
        check("1d_done_rel9", {31'd0, done}, 1);
        check("1d_busy_rel9", {31'd0, busy}, 0);
        check("1d_addr_hold", {16'd0, addr}, 13);
        repeat (6) tick();
        check("1d_drain", q.size(), 0);

        // 2D pass; dims 2,3 carry nonzero extents that must be ignored.
        cfg_num_dims    = 3'd2;
        cfg_extent_m1   = {16'd5, 16'd5, 16'd1, 16'd2};
        cfg_start_addr  = 16'd0;
        cfg_addr_delta  = {16'd500, 16'd400, 16'd62, 16'd1};
        cfg_start_cycle = 16'd0;
        cfg_sched_delta = {16'd50, 16'd40, 16'd3, 16'd1};
        push(16'd0, 0); push(16'd1, 1); push(16'd2, 2);
        push(16'd64, 5); push(16'd65, 6); push(16'd66, 7);
        do_start();
        check("2d_done_clear", {31'd0, done}, 0);
        wait_rel(12);
        check("2d_done", {31'd0, done}, 1);
        check("2d_drain", q.size(), 0);

        // clk_en low for 3 cycles at cnt=1 shifts every issue by 3.
        cfg_1d(16'd10, 16'd5);
        push(16'd10, 8); push(16'd11, 9); push(16'd12, 10); push(16'd13, 11);
        do_start();
        wait_rel(1);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("gated_en", {31'd0, en}, 0);
            tick();
        end
        clk_en = 1'b1;
        wait_rel(13);
        check("gated_done", {31'd0, done}, 1);
        check("gated_drain", q.size(), 0);

        // Restart after two issues: new pass uses the new start addr/cycle.
        cfg_1d(16'd10, 16'd2);
        push(16'd10, 2); push(16'd11, 3);
        do_start();
        wait_rel(3);
        cfg_1d(16'd100, 16'd3);
        push(16'd100, 3); push(16'd101, 4); push(16'd102, 5); push(16'd103, 6);
        do_start();
        check("restart_rel", rel, 0);
        check("restart_done", {31'd0, done}, 0);
        check("restart_busy", {31'd0, busy}, 1);
        check("restart_addr", {16'd0, addr}, 100);
        wait_rel(8);
        check("restart_fin", {31'd0, done}, 1);
        check("restart_drain", q.size(), 0);

        // Reset mid-pass aborts; nothing issues afterwards.
        cfg_1d(16'd10, 16'd5);
        push(16'd10, 5); push(16'd11, 6);
        do_start();
        wait_rel(6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_en", {31'd0, en}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_addr", {16'd0, addr}, 0);
        check("rst_done", {31'd0, done}, 0);
        repeat (12) tick();
        check("rst_busy_later", {31'd0, busy}, 0);
        check("rst_drain", q.size(), 0);

        // Zero schedule delta: one issue, then a miss (flagged if enabled).
        cfg_num_dims    = 3'd0;
        cfg_extent_m1   = {16'd0, 16'd0, 16'd0, 16'd1};
        cfg_start_addr  = 16'd7;
        cfg_addr_delta  = {16'd0, 16'd0, 16'd0, 16'd2};
        cfg_start_cycle = 16'd4;
        cfg_sched_delta = {16'd0, 16'd0, 16'd0, 16'd0};
        push(16'd7, 4);
        do_start();
        wait_rel(4);
        check("miss_err_at_issue", {31'd0, err}, 0);
        wait_rel(5);
`ifdef MEM_ADDRGEN_MISS_DETECT_EN
        check("miss_err", {31'd0, err}, 1);
        wait_rel(9);
        check("miss_err_sticky", {31'd0, err}, 1);
`else
        check("miss_err", {31'd0, err}, 0);
        wait_rel(9);
        check("miss_err_sticky", {31'd0, err}, 0);
`endif
        check("miss_busy", {31'd0, busy}, 1);
        check("miss_addr", {16'd0, addr}, 9);
        check("miss_drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_affine_addrgen.md
Name: mem_affine_addrgen

Overview:
Affine loop-nest address/schedule generator that drives the external-addrgen port pair of one memory tile: write_addr/wen or read_addr/ren. It sits directly upstream of the mem tile.
- Configured with start address, start cycle, per-dimension extents and delta-encoded strides.
- Emits one enable pulse plus address exactly on each scheduled cycle.
- One instance is used per mem port; the sched min/max of the port map to start cycle and last issue.

Parameters:
NUM_DIMS, 4, maximum loop-nest depth supported.
ADDR_W, 16, address width; matches mem addr port.
CYC_W, 16, cycle counter / schedule width.
EXT_W, 16, per-dimension extent counter width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clk_en  in  1  global clock enable; low freezes all state
start  in  1  pulse: latch config, begin new pass (restarts if busy)
cfg_num_dims  in  3  active dims, 1..NUM_DIMS
cfg_extent_m1  in  NUM_DIMS*EXT_W  per-dim extent minus 1, dim0 = innermost = LSBs
cfg_start_addr  in  ADDR_W  first address
cfg_addr_delta  in  NUM_DIMS*ADDR_W  address increment applied when dim d is highest dim to step
cfg_start_cycle  in  CYC_W  cycle of first issue
cfg_sched_delta  in  NUM_DIMS*CYC_W  schedule increment, same rule
en  out  1  issue strobe to mem wen_0/ren_0
addr  out  ADDR_W  address to mem write_addr_0/read_addr_0
busy  out  1  pass in progress
done  out  1  sticky: pass complete
err  out  1  sticky schedule-miss flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge, regardless of clk_en): state=IDLE; cnt, indices, addr_reg, sched_reg=0; en=0, addr=0, busy=0, done=0, err=0. Reset during a pass aborts it; no further en.
- States:
  - IDLE --start--> RUN.
  - RUN --last issue--> DONE.
  - DONE --start--> RUN.
  - start in RUN: restart; the in-flight pass is discarded.
- Start edge (clk_en=1):
  - latch all cfg_*; indices=0; addr_reg=cfg_start_addr; sched_reg=cfg_start_cycle; cnt=0; done=0; err=0.
  - cnt=0 in the first cycle after start.
- RUN, clk_en=1: cnt increments each cycle, wrapping modulo 2^CYC_W.
- Issue:
  - en = (state==RUN) && clk_en && (cnt==sched_reg).
  - addr = addr_reg whenever state==RUN; holds last value otherwise.
  - en and addr derive from registers only; no combinational path from cfg inputs.
- On issue, d = lowest dim whose index != extent_m1 (among active dims):
  - indices[0..d-1] wrap to 0; index[d] increments.
  - addr_reg += addr_delta[d]; sched_reg += sched_delta[d], modulo width.
- If no such d, this issue is the last: next state DONE, busy=0, done=1.
- Dims >= cfg_num_dims are ignored (treated as extent 1); cfg_num_dims=0 is treated as 1.
- clk_en=0: cnt, state, indices and regs hold; en=0.
- Total issues per pass = product of (extent_m1+1) over active dims.
- Latency: en asserts in the cycle where cnt equals sched_reg; the mem samples at that edge.

Optional Feature:
MEM_ADDRGEN_MISS_DETECT_EN.
- Defined: in RUN, if the post-issue sched_reg <= cnt (sched_delta 0 or overflow), err is set sticky; the generator then waits for the cnt wrap and keeps running.
- Undefined: err tied 0; no comparator logic.

Decomposition:
- Package mem_addrgen_pkg: state enum (IDLE, RUN, DONE); MAX_DIMS=NUM_DIMS default; packed config struct type; ext/addr/cyc width localparams.
- Sub-module mem_addrgen_iter: the loop-nest index counter. Outputs step dimension d and a last flag. The top module holds cnt, FSM and the affine accumulators.

Test Plan:
- 1D: extent_m1=3, start_addr=10, addr_delta0=1, start_cycle=5, sched_delta0=1 -> en at cnt 5,6,7,8 with addr 10,11,12,13; done=1 from cnt 9; no en after.
- 2D: extent_m1={2,1}, addr_delta={1,62}, sched_delta={1,3}, start 0/0 -> addr 0,1,2,64,65,66 at cnt 0,1,2,5,6,7; then done.
- clk_en dropped for 3 cycles at cnt=1 of the 1D case -> en=0 while low; issue times shift by 3; addrs unchanged.
- start re-asserted mid-pass (after 2 issues) -> done=0, cnt=0, next issue at start_cycle with cfg_start_addr.
- rst_n=0 mid-pass for 1 cycle -> en=0, busy=0, addr=0 next cycle; no issues until a new start.
- With MEM_ADDRGEN_MISS_DETECT_EN: sched_delta0=0, extent_m1=1 -> first issue at start_cycle, err=1 the following cycle and stays set; without the macro err=0.
